// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request, response and memory-port signals of the load/store unit.
// Optional feature macro: LSU_SIGNED_LOAD_EN adds in_req_signed to the request group.
// slave  = the load/store unit itself
// master = CPU datapath plus data memory that surround it
interface load_store_unit_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic                  in_req_valid;
    logic                  out_req_ready;
    logic                  in_req_write;
    logic                  in_req_wide;
    logic [ADDR_W-1:0]     in_req_addr;
    logic [2*DATA_W-1:0]   in_req_wdata;
`ifdef LSU_SIGNED_LOAD_EN
    logic                  in_req_signed;
`endif
    logic                  out_resp_valid;
    logic                  in_resp_ready;
    logic [2*DATA_W-1:0]   out_resp_rdata;
    logic [ADDR_W-1:0]     out_mem_addr;
    logic                  out_mem_write_en;
    logic [DATA_W-1:0]     out_mem_data;
    logic [DATA_W-1:0]     in_mem_data;

    modport slave (
`ifdef LSU_SIGNED_LOAD_EN
        input  in_req_signed,
`endif
        input  in_req_valid, in_req_write, in_req_wide, in_req_addr, in_req_wdata,
        input  in_resp_ready, in_mem_data,
        output out_req_ready, out_resp_valid, out_resp_rdata,
        output out_mem_addr, out_mem_write_en, out_mem_data
    );

    modport master (
`ifdef LSU_SIGNED_LOAD_EN
        output in_req_signed,
`endif
        output in_req_valid, in_req_write, in_req_wide, in_req_addr, in_req_wdata,
        output in_resp_ready, in_mem_data,
        input  out_req_ready, out_resp_valid, out_resp_rdata,
        input  out_mem_addr, out_mem_write_en, out_mem_data
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: sequences 8/16-bit loads and stores onto a byte-wide, write-first,
// synchronous data memory and returns one response per request.
// Optional feature macro: LSU_SIGNED_LOAD_EN (sign-extending narrow loads).
module load_store_unit #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ACC_LO, ACC_HI, FIN, RESP} state_t;

    state_t                state;
    state_t                state_nxt;

    // Request fields latched at accept; later changes on the request bus are ignored.
    logic [ADDR_W-1:0]     addr_q;
    logic                  write_q;
    logic                  wide_q;
    logic [2*DATA_W-1:0]   wdata_q;
    logic                  narrow_sext;

    logic                  resp_valid_q;
    logic [2*DATA_W-1:0]   rdata_q;

    // Upper byte of a narrow result: copies of the byte's sign bit, or zero.
    function automatic logic [DATA_W-1:0] upper_fill(input logic signed [DATA_W-1:0] b,
                                                     input logic sext);
        return sext ? {DATA_W{b[DATA_W-1]}} : '0;
    endfunction

`ifdef LSU_SIGNED_LOAD_EN
    logic sext_q;

    // Signed flag latched at accept; stores never sign-extend their read-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sext_q <= 1'b0;
        end else if (state == IDLE && bus.in_req_valid) begin
            sext_q <= bus.in_req_signed & ~bus.in_req_write;
        end
    end

    assign narrow_sext = sext_q;
`else
    assign narrow_sext = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one memory cycle per byte, one cycle to collect the last byte.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_req_valid) state_nxt = ACC_LO;
            ACC_LO:  state_nxt = wide_q ? ACC_HI : FIN;
            ACC_HI:  state_nxt = FIN;
            FIN:     state_nxt = RESP;
            RESP:    if (bus.in_resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port and request-ready, decoded from state and the latched request.
    always_comb begin
        bus.out_req_ready    = 1'b0;
        bus.out_mem_addr     = '0;
        bus.out_mem_data     = '0;
        bus.out_mem_write_en = 1'b0;
        case (state)
            IDLE: begin
                bus.out_req_ready = 1'b1;
            end
            ACC_LO: begin
                bus.out_mem_addr     = addr_q;
                bus.out_mem_data     = wdata_q[DATA_W-1:0];
                bus.out_mem_write_en = write_q;
            end
            ACC_HI: begin
                // Address arithmetic wraps at the top of memory.
                bus.out_mem_addr     = addr_q + ADDR_W'(1);
                bus.out_mem_data     = wdata_q[2*DATA_W-1:DATA_W];
                bus.out_mem_write_en = write_q;
            end
            default: ;
        endcase
    end

    // Request latch, read-data assembly and response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            write_q      <= 1'b0;
            wide_q       <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_req_valid) begin
                        addr_q  <= bus.in_req_addr;
                        write_q <= bus.in_req_write;
                        wide_q  <= bus.in_req_wide;
                        wdata_q <= bus.in_req_wdata;
                    end
                end
                ACC_HI: begin
                    // Memory now shows the low byte sampled in ACC_LO.
                    rdata_q[DATA_W-1:0] <= bus.in_mem_data;
                end
                FIN: begin
                    if (wide_q) begin
                        rdata_q[2*DATA_W-1:DATA_W] <= bus.in_mem_data;
                    end else begin
                        rdata_q[DATA_W-1:0]        <= bus.in_mem_data;
                        rdata_q[2*DATA_W-1:DATA_W] <= upper_fill(bus.in_mem_data, narrow_sext);
                    end
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (bus.in_resp_ready) resp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_resp_valid = resp_valid_q;
    assign bus.out_resp_rdata = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven, hand-sequenced and randomized checks of load_store_unit
// against a byte-array reference model. Builds with or without LSU_SIGNED_LOAD_EN.
module tb_load_store_unit;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
`ifdef LSU_SIGNED_LOAD_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    load_store_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks;
    int failures;

    // Data memory environment: synchronous, write-first, preset contents from init_byte.
    logic [7:0] mem [1024];
    bit         written [1024];
    logic [7:0] mem_rd;
    int         we_cnt = 0;

    function automatic logic [7:0] init_byte(input logic [9:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [9:0] a);
        return written[a] ? mem[a] : init_byte(a);
    endfunction

    always @(posedge clk) begin
        if (bus.out_mem_write_en) begin
            mem[bus.out_mem_addr]     <= bus.out_mem_data;
            written[bus.out_mem_addr] <= 1'b1;
            mem_rd                    <= bus.out_mem_data;
            we_cnt                    <= we_cnt + 1;
        end else begin
            mem_rd <= mem_byte(bus.out_mem_addr);
        end
    end
    assign bus.in_mem_data = mem_rd;

    // Reference model: byte array updated by stores, read by loads.
    logic [7:0] ref_mem [1024];

    function automatic logic [15:0] ref_expect(input logic w, input logic wd,
                                               input logic [9:0] a, input logic [15:0] d,
                                               input logic s);
        logic [9:0] a1;
        a1 = a + 10'd1;
        if (w) begin
            ref_mem[a] = d[7:0];
            if (wd) begin
                ref_mem[a1] = d[15:8];
                return d;
            end
            return {8'h00, d[7:0]};
        end
        if (wd) return {ref_mem[a1], ref_mem[a]};
        if (SIGNED_EN && s && ref_mem[a][7]) return {8'hFF, ref_mem[a]};
        return {8'h00, ref_mem[a]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic w, input logic wd,
                           input logic [9:0] a, input logic [15:0] d);
        bus.in_req_valid = v;
        bus.in_req_write = w;
        bus.in_req_wide  = wd;
        bus.in_req_addr  = a;
        bus.in_req_wdata = d;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!bus.out_resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_resp();
        bus.in_resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_resp_ready = 1'b0;
    endtask

    // One complete transaction; starts and ends 1 time unit after a rising edge.
    task automatic run_txn(input logic w, input logic wd, input logic [9:0] a,
                           input logic [15:0] d, input logic s, input int hold,
                           output logic [15:0] rd, output logic [15:0] exp,
                           output int lat, output int wes);
        int n;
        int we0;
        n = 0;
        while (!bus.out_req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        set_req(1'b1, w, wd, a, d);
`ifdef LSU_SIGNED_LOAD_EN
        bus.in_req_signed = s;
`endif
        exp = ref_expect(w, wd, a, d, s);
        we0 = we_cnt;
        @(posedge clk); #1;
        set_req(1'b0, 1'($urandom), 1'($urandom), 10'($urandom), 16'($urandom));
`ifdef LSU_SIGNED_LOAD_EN
        bus.in_req_signed = 1'($urandom);
`endif
        wait_resp(lat);
        rd = bus.out_resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.out_resp_valid), 32'h1);
            check("hold_rdata", 32'(bus.out_resp_rdata), 32'(exp));
            check("hold_busy", 32'(bus.out_req_ready), 32'h0);
        end
        take_resp();
        wes = we_cnt - we0;
    endtask

    typedef struct {
        logic        w;
        logic        wd;
        logic [9:0]  a;
        logic [15:0] d;
        logic        s;
        logic [15:0] exp_rd;
        int          exp_lat;
        int          exp_we;
    } vec_t;

    localparam int NV = 14;
    localparam logic [15:0] SEXT_80 = SIGNED_EN ? 16'hFF80 : 16'h0080;

    initial begin
        vec_t        vecs [NV];
        logic [15:0] rd, exp, exp2;
        int          lat, wes, hits, errs;
        logic        rw, rwd, rs;
        logic [9:0]  ra;
        logic [15:0] rdat;

        checks   = 0;
        failures = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(10'(i));

        vecs[0]  = '{1'b1, 1'b0, 10'h005, 16'h00A5, 1'b0, 16'h00A5, 2, 1};
        vecs[1]  = '{1'b0, 1'b0, 10'h005, 16'h0000, 1'b0, 16'h00A5, 2, 0};
        vecs[2]  = '{1'b1, 1'b1, 10'h3FF, 16'hBEEF, 1'b0, 16'hBEEF, 3, 2};
        vecs[3]  = '{1'b0, 1'b1, 10'h3FF, 16'h0000, 1'b0, 16'hBEEF, 3, 0};
        vecs[4]  = '{1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 16'h00BE, 2, 0};
        vecs[5]  = '{1'b0, 1'b0, 10'h3FF, 16'h0000, 1'b0, 16'h00EF, 2, 0};
        vecs[6]  = '{1'b1, 1'b0, 10'h020, 16'h1280, 1'b0, 16'h0080, 2, 1};
        vecs[7]  = '{1'b0, 1'b0, 10'h020, 16'h0000, 1'b0, 16'h0080, 2, 0};
        vecs[8]  = '{1'b0, 1'b0, 10'h020, 16'h0000, 1'b1, SEXT_80,  2, 0};
        vecs[9]  = '{1'b0, 1'b1, 10'h020, 16'h0000, 1'b1, 16'h7B80, 3, 0};
        vecs[10] = '{1'b1, 1'b1, 10'h100, 16'h8001, 1'b1, 16'h8001, 3, 2};
        vecs[11] = '{1'b0, 1'b0, 10'h101, 16'h0000, 1'b1, SEXT_80,  2, 0};
        vecs[12] = '{1'b1, 1'b0, 10'h030, 16'h5AC3, 1'b1, 16'h00C3, 2, 1};
        vecs[13] = '{1'b0, 1'b0, 10'h031, 16'h0000, 1'b0, 16'h006B, 2, 0};

        bus.in_resp_ready = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
`ifdef LSU_SIGNED_LOAD_EN
        bus.in_req_signed = 1'b0;
`endif
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_req_ready", 32'(bus.out_req_ready), 32'h1);
        check("rst_resp_valid", 32'(bus.out_resp_valid), 32'h0);
        check("rst_resp_rdata", 32'(bus.out_resp_rdata), 32'h0);
        check("rst_mem_we", 32'(bus.out_mem_write_en), 32'h0);
        check("rst_mem_addr", 32'(bus.out_mem_addr), 32'h0);
        check("rst_mem_data", 32'(bus.out_mem_data), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        for (int i = 0; i < NV; i++) begin
            run_txn(vecs[i].w, vecs[i].wd, vecs[i].a, vecs[i].d, vecs[i].s, 0, rd, exp, lat, wes);
            check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_we_cycles", i), 32'(wes), 32'(vecs[i].exp_we));
        end
        check("wrap_mem_3ff", 32'(mem_byte(10'h3FF)), 32'h00EF);
        check("wrap_mem_000", 32'(mem_byte(10'h000)), 32'h00BE);

        // Back-pressure: response held for 5 cycles while a second request waits.
        check("bp_idle_ready", 32'(bus.out_req_ready), 32'h1);
        set_req(1'b1, 1'b0, 1'b0, 10'h005, 16'h0000);
        exp = ref_expect(1'b0, 1'b0, 10'h005, 16'h0000, 1'b0);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b1, 10'h3FF, 16'h0000);
        exp2 = ref_expect(1'b0, 1'b1, 10'h3FF, 16'h0000, 1'b0);
        check("bp_busy_after_accept", 32'(bus.out_req_ready), 32'h0);
        wait_resp(lat);
        check("bp_latency", 32'(lat), 32'h2);
        check("bp_rdata", 32'(bus.out_resp_rdata), 32'(exp));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(bus.out_resp_valid), 32'h1);
            check("bp_hold_rdata", 32'(bus.out_resp_rdata), 32'h00A5);
            check("bp_hold_busy", 32'(bus.out_req_ready), 32'h0);
        end
        take_resp();
        check("bp_released_valid", 32'(bus.out_resp_valid), 32'h0);
        check("bp_released_ready", 32'(bus.out_req_ready), 32'h1);
        @(posedge clk); #1;
        check("bp_second_accepted", 32'(bus.out_req_ready), 32'h0);
        set_req(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
        wait_resp(lat);
        check("bp_second_latency", 32'(lat), 32'h3);
        check("bp_second_rdata", 32'(bus.out_resp_rdata), 32'(exp2));
        take_resp();

        // Busy rejection: a request raised during ACC_LO waits until IDLE.
        set_req(1'b1, 1'b1, 1'b1, 10'h040, 16'h4321);
        exp = ref_expect(1'b1, 1'b1, 10'h040, 16'h4321, 1'b0);
        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 1'b0, 10'h050, 16'h0077);
        lat  = 0;
        hits = 0;
        while (!bus.out_resp_valid && lat < 20) begin
            if (bus.out_mem_write_en && bus.out_mem_addr == 10'h050) hits++;
            @(posedge clk); #1;
            lat++;
        end
        check("busy_no_early_write", 32'(hits), 32'h0);
        check("busy_first_latency", 32'(lat), 32'h3);
        check("busy_first_rdata", 32'(bus.out_resp_rdata), 32'(exp));
        check("busy_mem050_untouched", 32'(mem_byte(10'h050)), 32'(init_byte(10'h050)));
        take_resp();
        check("busy_idle_ready", 32'(bus.out_req_ready), 32'h1);
        exp2 = ref_expect(1'b1, 1'b0, 10'h050, 16'h0077, 1'b0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
        wait_resp(lat);
        check("busy_second_latency", 32'(lat), 32'h2);
        check("busy_second_rdata", 32'(bus.out_resp_rdata), 32'(exp2));
        take_resp();
        check("busy_mem050_written", 32'(mem_byte(10'h050)), 32'h0077);

        // Reset during ACC_HI of a wide store: low byte lands, high byte does not.
        set_req(1'b1, 1'b1, 1'b1, 10'h010, 16'h1234);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000);
        @(posedge clk); #1;
        check("rmid_acc_hi_we", 32'(bus.out_mem_write_en), 32'h1);
        check("rmid_acc_hi_addr", 32'(bus.out_mem_addr), 32'h011);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_we_drop", 32'(bus.out_mem_write_en), 32'h0);
        check("rmid_addr_zero", 32'(bus.out_mem_addr), 32'h0);
        check("rmid_resp_valid", 32'(bus.out_resp_valid), 32'h0);
        ref_mem[10'h010] = 8'h34;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rmid_ready_after", 32'(bus.out_req_ready), 32'h1);
        check("rmid_valid_after", 32'(bus.out_resp_valid), 32'h0);
        check("rmid_mem010", 32'(mem_byte(10'h010)), 32'h0034);
        check("rmid_mem011", 32'(mem_byte(10'h011)), 32'(init_byte(10'h011)));

        // Randomized traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            rw   = 1'($urandom);
            rwd  = 1'($urandom);
            rs   = 1'($urandom);
            ra   = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 47));
            rdat = 16'($urandom);
            run_txn(rw, rwd, ra, rdat, rs, $urandom_range(0, 2), rd, exp, lat, wes);
            check($sformatf("rnd%0d_rdata", i), 32'(rd), 32'(exp));
            check($sformatf("rnd%0d_latency", i), 32'(lat), rwd ? 32'h3 : 32'h2);
            check($sformatf("rnd%0d_we_cycles", i), 32'(wes), rw ? (rwd ? 32'h2 : 32'h1) : 32'h0);
        end

        errs = 0;
        for (int a = 0; a < 1024; a++) begin
            if (mem_byte(10'(a)) !== ref_mem[a]) errs++;
        end
        check("mem_sweep_mismatches", 32'(errs), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the byte-wide data memory (10-bit address, 8-bit data, synchronous write-first access, read data valid after the clock edge that sampled the address).
- Accepts load/store requests from the CPU datapath over a valid/ready handshake.
- Splits 16-bit accesses into two byte accesses, sequences the memory port, assembles read data and returns a single response over a valid/ready handshake.

Parameters:
- ADDR_W, 10, memory address width; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 8, memory data width; the request/response data path is 2*DATA_W.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_req_valid  input  1  request present.
- out_req_ready  output  1  unit can accept a request.
- in_req_write  input  1  1 = store, 0 = load.
- in_req_wide  input  1  1 = 16-bit access, 0 = 8-bit access.
- in_req_addr  input  ADDR_W  byte address.
- in_req_wdata  input  2*DATA_W  store data; only bits [7:0] are used when narrow.
- out_resp_valid  output  1  response present.
- in_resp_ready  input  1  consumer takes the response.
- out_resp_rdata  output  2*DATA_W  load data, or read-back of the stored data for stores.
- out_mem_addr  output  ADDR_W  to memory address input.
- out_mem_write_en  output  1  to memory write enable.
- out_mem_data  output  DATA_W  to memory write data.
- in_mem_data  input  DATA_W  from memory read data.

Behaviour:
- States: IDLE, ACC_LO, ACC_HI, FIN, RESP.
- Reset (async, rst_n=0) values:
  - state=IDLE.
  - out_resp_valid=0, out_resp_rdata=0.
  - out_mem_write_en=0, out_mem_addr=0, out_mem_data=0.
  - out_req_ready=1 once in IDLE.
  - All latched request fields cleared.
- IDLE:
  - out_req_ready=1.
  - On an edge with in_req_valid=1, latch addr, write, wide and wdata, then go to ACC_LO.
  - out_mem_write_en=0.
- ACC_LO:
  - out_mem_addr=A, out_mem_data=wdata[7:0], out_mem_write_en=write.
  - Next state: ACC_HI if wide, else FIN.
- ACC_HI:
  - out_mem_addr=(A+1) mod 2^ADDR_W; address 1023 wraps to 0.
  - out_mem_data=wdata[15:8], out_mem_write_en=write.
  - At the edge leaving this state, capture rdata[7:0]<=in_mem_data (the low-byte result).
  - Next state: FIN.
- FIN:
  - out_mem_write_en=0.
  - At the edge leaving this state: if wide, rdata[15:8]<=in_mem_data; else rdata[7:0]<=in_mem_data and rdata[15:8]<=0.
  - Set out_resp_valid<=1. Next state: RESP.
- RESP:
  - out_resp_valid=1 and out_resp_rdata are held stable until an edge with in_resp_ready=1.
  - On that edge, out_resp_valid<=0 and go to IDLE.
- out_req_ready=0 in every state except IDLE. Requests presented while busy are ignored and must be held by the source.
- Latency from the accept edge to out_resp_valid high:
  - narrow: 2 edges (third cycle);
  - wide: 3 edges.
- Throughput: one request per 4 cycles (narrow) or 5 cycles (wide), assuming in_resp_ready=1.
- Memory drive signals are combinational from state and latched fields; out_mem_write_en is never high outside ACC_LO/ACC_HI.
- Store response rdata equals the written data, because the memory is write-first.
- Reset mid-operation: all outputs return to reset values immediately, and any pending response is dropped. A wide store reset while in ACC_HI leaves the low byte written and the high byte unwritten (documented, not corrected).
- Request fields changing after acceptance have no effect.

Optional Feature:
- Macro: LSU_SIGNED_LOAD_EN.
- With the macro defined:
  - Extra port in_req_signed (input, 1), latched at accept.
  - Narrow loads with signed=1 set rdata[15:8] to eight copies of bit 7 of the loaded byte.
  - Wide accesses and stores ignore signed.
- Without the macro: the port is absent and narrow loads always zero-extend.

Test Plan:
- Narrow store addr=0x005 data=0x00A5, then narrow load addr=0x005 -> mem[5]=0xA5; load response rdata=0x00A5 two edges after accept; out_mem_write_en pulsed exactly one cycle for the store.
- Wide store addr=0x3FF data=0xBEEF -> mem[0x3FF]=0xEF, mem[0x000]=0xBE (wrap); wide load addr=0x3FF returns 0xBEEF after 3 edges.
- Back-pressure: narrow load completes with in_resp_ready=0 for 5 cycles -> out_resp_valid and rdata held constant; out_req_ready=0 throughout; a second request is not accepted until one cycle after in_resp_ready=1.
- Busy rejection: a request with in_req_valid=1 arrives while the unit is in ACC_LO -> no memory activity for it until the unit returns to IDLE; it is then accepted and executes correctly.
- Reset mid-op: assert rst_n=0 asynchronously during ACC_HI of wide store 0x1234 to addr 0x010 -> out_mem_write_en drops immediately; mem[0x010]=0x34, mem[0x011] unchanged; out_resp_valid=0; out_req_ready=1 after release.
- LSU_SIGNED_LOAD_EN: mem[0x020]=0x80, narrow load with signed=1 -> 0xFF80; with signed=0 -> 0x0080; macro undefined -> 0x0080.
